// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - UART transmit serializer stepping one bit per external baud tick
module uart_tx_serializer #(
    parameter int DATA_W     = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic              baud_tick,
    output logic              baud_en,
    output logic              tx,
    output logic              tx_busy,
    output logic              tx_done
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]        state;
    logic [DATA_W-1:0] shreg;
    logic [2:0]        bit_cnt;
    logic              parity_acc;
    logic              stop_cnt;

    assign tx_ready = (state == S_IDLE);
    assign baud_en  = (state != S_IDLE);
    assign tx_busy  = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            tx         <= 1'b1;
            tx_done    <= 1'b0;
            shreg      <= '0;
            bit_cnt    <= '0;
            parity_acc <= 1'b0;
            stop_cnt   <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (tx_valid) begin
                        shreg      <= tx_data;
                        // Seeding with the odd flag leaves the finished accumulator equal to the parity bit
                        parity_acc <= 1'(PARITY_ODD);
                        bit_cnt    <= '0;
                        stop_cnt   <= 1'b0;
                        tx         <= 1'b0;
                        state      <= S_START;
                    end
                end
                S_START: begin
                    if (baud_tick) begin
                        tx         <= shreg[0];
                        parity_acc <= parity_acc ^ shreg[0];
                        shreg      <= shreg >> 1;
                        state      <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (baud_tick) begin
                        if (bit_cnt == 3'(DATA_W - 1)) begin
                            if (PARITY_EN != 0) begin
                                tx    <= parity_acc;
                                state <= S_PARITY;
                            end else begin
                                tx    <= 1'b1;
                                state <= S_STOP;
                            end
                        end else begin
                            tx         <= shreg[0];
                            parity_acc <= parity_acc ^ shreg[0];
                            shreg      <= shreg >> 1;
                            bit_cnt    <= bit_cnt + 3'd1;
                        end
                    end
                end
                S_PARITY: begin
                    if (baud_tick) begin
                        tx    <= 1'b1;
                        state <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (baud_tick) begin
                        if (stop_cnt == 1'(STOP_BITS - 1)) begin
                            state   <= S_IDLE;
                            tx_done <= 1'b1;
                        end else begin
                            stop_cnt <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb/tb_uart_tx_serializer.sv - randomized bench for uart_tx_serializer against a frame-level model
module tb_uart_tx_serializer;

    localparam int B    = 16;
    localparam int NCFG = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       force_tick = 1'b0;

    logic tx_w [NCFG];
    logic ready_w [NCFG];
    logic baud_en_w [NCFG];
    logic busy_w [NCFG];
    logic done_w [NCFG];

    int checks = 0;
    int errors = 0;

    logic [9:0] exp_a5 = 10'b1101001010;

    always #5 clk = ~clk;

    // cfg0: 8N1, cfg1: 8E1, cfg2: 8O1, cfg3: 8N2
    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        localparam int P_EN  = (g == 1 || g == 2) ? 1 : 0;
        localparam int P_ODD = (g == 2) ? 1 : 0;
        localparam int SB    = (g == 3) ? 2 : 1;
        localparam int NBITS = 1 + 8 + P_EN + SB;

        logic [3:0] bcnt;
        logic       baud_tick;
        int         m_cyc = -1;
        logic [7:0] m_data = 8'h00;
        logic       m_done = 1'b0;
        int         checks = 0;
        int         errors = 0;

        always @(posedge clk or negedge rst_n) begin
            if (!rst_n)             bcnt <= 4'd0;
            else if (!baud_en_w[g]) bcnt <= 4'd0;
            else                    bcnt <= bcnt + 4'd1;
        end
        assign baud_tick = (baud_en_w[g] && bcnt == 4'd15) || force_tick;

        uart_tx_serializer #(
            .DATA_W(8), .PARITY_EN(P_EN), .PARITY_ODD(P_ODD), .STOP_BITS(SB)
        ) dut (
            .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
            .tx_ready(ready_w[g]), .baud_tick(baud_tick), .baud_en(baud_en_w[g]),
            .tx(tx_w[g]), .tx_busy(busy_w[g]), .tx_done(done_w[g])
        );

        function automatic logic frame_bit(input logic [7:0] d, input int i);
            if (i == 0) return 1'b0;
            if (i <= 8) return d[i-1];
            if (P_EN == 1 && i == 9) return (^d) ^ 1'(P_ODD);
            return 1'b1;
        endfunction

        // Model: m_cyc counts cycles since the accept edge, -1 when idle
        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                m_cyc  <= -1;
                m_done <= 1'b0;
            end else begin
                m_done <= 1'b0;
                if (m_cyc >= 0) begin
                    if (m_cyc + 1 == NBITS * B) begin
                        m_cyc  <= -1;
                        m_done <= 1'b1;
                    end else begin
                        m_cyc <= m_cyc + 1;
                    end
                end else if (tx_valid) begin
                    m_cyc  <= 0;
                    m_data <= tx_data;
                end
            end
        end

        task automatic chk(input string nm, input logic act, input logic exp);
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL cfg%0d %s at %0t: got %b expected %b", g, nm, $time, act, exp);
            end
        endtask

        always @(negedge clk) begin
            logic busy;
            logic etx;
            busy = (m_cyc >= 0);
            etx  = busy ? frame_bit(m_data, m_cyc / B) : 1'b1;
            chk("tx", tx_w[g], etx);
            chk("tx_ready", ready_w[g], !busy);
            chk("baud_en", baud_en_w[g], busy);
            chk("tx_busy", busy_w[g], busy);
            chk("tx_done", done_w[g], m_done);
        end
    end

    task automatic mchk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    task automatic accept_all(input logic [7:0] d);
        @(posedge clk); #1;
        tx_valid = 1'b1;
        tx_data  = d;
        @(posedge clk); #1;
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
    endtask

    task automatic toggle_in_reset(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            tx_valid   = 1'($urandom);
            tx_data    = 8'($urandom);
            force_tick = 1'($urandom);
        end
        @(negedge clk);
        for (int i = 0; i < NCFG; i++) begin
            mchk("rst_tx", 32'(tx_w[i]), 1);
            mchk("rst_ready", 32'(ready_w[i]), 1);
            mchk("rst_baud_en", 32'(baud_en_w[i]), 0);
            mchk("rst_busy", 32'(busy_w[i]), 0);
            mchk("rst_done", 32'(done_w[i]), 0);
        end
        @(posedge clk); #1;
        tx_valid   = 1'b0;
        force_tick = 1'b0;
        rst_n      = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    initial begin
        int done_at [NCFG];
        int fall_at;
        int stop_hi;

        #1 rst_n = 1'b0;
        toggle_in_reset(6);

        // 0xA5 on all configs: pin bit values and frame lengths
        for (int i = 0; i < NCFG; i++) done_at[i] = -1;
        accept_all(8'hA5);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (k % 16 == 8 && k < 160) mchk("a5_bit", 32'(tx_w[0]), 32'(exp_a5[k/16]));
            for (int i = 0; i < NCFG; i++)
                if (done_w[i] && done_at[i] < 0) done_at[i] = k;
        end
        mchk("a5_done_at_8n1", done_at[0], 160);
        mchk("a5_done_at_8e1", done_at[1], 176);
        mchk("a5_done_at_8n2", done_at[3], 176);

        // 0x07 parity bit
        accept_all(8'h07);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (k == 9 * 16 + 8) begin
                mchk("parity_even_07", 32'(tx_w[1]), 1);
                mchk("parity_odd_07", 32'(tx_w[2]), 0);
            end
        end

        // back-to-back with tx_valid held high
        fall_at = -1;
        @(posedge clk); #1;
        tx_valid = 1'b1;
        tx_data  = 8'h3C;
        @(posedge clk); #1;
        tx_data  = 8'hC3;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (k == 160) begin
                mchk("b2b_done", 32'(done_w[0]), 1);
                mchk("b2b_ready_with_done", 32'(ready_w[0]), 1);
            end
            if (k > 150 && fall_at < 0 && tx_w[0] == 1'b0) fall_at = k;
            if (k == 177) tx_valid = 1'b0;
        end
        mchk("b2b_start_gap", fall_at - 144, 17);
        repeat (200) @(posedge clk);

        // reset during data bit 3 of 0xFF
        accept_all(8'hFF);
        for (int k = 0; k <= 70; k++) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < NCFG; i++) begin
            mchk("midframe_rst_tx", 32'(tx_w[i]), 1);
            mchk("midframe_rst_done", 32'(done_w[i]), 0);
        end
        toggle_in_reset(3);
        accept_all(8'h00);
        repeat (200) @(posedge clk);

        // idle ticks are ignored, then two stop bits
        repeat (5) begin
            @(posedge clk); #1 force_tick = 1'b1;
            @(posedge clk); #1 force_tick = 1'b0;
        end
        @(negedge clk);
        mchk("idle_tick_busy", 32'(busy_w[3]), 0);
        mchk("idle_tick_tx", 32'(tx_w[3]), 1);
        stop_hi = 0;
        done_at[3] = -1;
        accept_all(8'h5A);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (k >= 144 && k < 176 && tx_w[3] == 1'b1) stop_hi++;
            if (done_w[3] && done_at[3] < 0) done_at[3] = k;
        end
        mchk("stop2_high_cycles", stop_hi, 32);
        mchk("stop2_done_at", done_at[3], 176);

        // random traffic, data wiggling mid-frame
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            tx_valid = ($urandom_range(0, 3) == 0);
            tx_data  = 8'($urandom);
        end
        tx_valid = 1'b0;
        repeat (200) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks + g_cfg[0].checks + g_cfg[1].checks + g_cfg[2].checks + g_cfg[3].checks,
                 errors + g_cfg[0].errors + g_cfg[1].errors + g_cfg[2].errors + g_cfg[3].errors);
        $finish;
    end

endmodule
